tri_raster_walker: RTL and testbench

//  Sequential triangle rasterizer for the FPGA render path. Accepts one screen-space triangle,

---
 rtl/tri_raster_walker.sv | 154 +++++++++++++++
 tb/tb_tri_raster_walker.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_raster_walker.sv
// Sequential triangle rasterizer: clips the bounding box, walks it row-major and
// streams every pixel covered by all three edge functions to the framebuffer writer.
module tri_raster_walker #(
  parameter int COORD_W = 8,
  parameter int X_MAX   = 159,
  parameter int Y_MAX   = 119
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COORD_W-1:0] x2,
  input  logic [COORD_W-1:0] y2,
  output logic               px_valid,
  input  logic               px_ready,
  output logic [COORD_W-1:0] px_x,
  output logic [COORD_W-1:0] px_y,
  output logic               busy,
  output logic               done,
  output logic [2:0]         dbg_state
);
  localparam int EW = 2 * COORD_W + 3;

  // Handshakes: a transfer happens on a rising edge where valid && ready; once
  // px_valid is high, px_x/px_y stay unchanged until that transfer takes place.

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SCAN, S_DRAIN, S_DONE} state_t;
  state_t state;

  logic [COORD_W-1:0] vx0, vy0, vx1, vy1, vx2, vy2;
  logic [COORD_W-1:0] xmin, xmax, ymin, ymax, cx, cy;
  logic               area_neg;

  function automatic logic signed [EW-1:0] edge_fn(
    input logic [COORD_W-1:0] ax, ay, bx, by, qx, qy);
    logic signed [EW-1:0] sax, say, sbx, sby, sqx, sqy;
    sax = signed'(EW'(ax));
    say = signed'(EW'(ay));
    sbx = signed'(EW'(bx));
    sby = signed'(EW'(by));
    sqx = signed'(EW'(qx));
    sqy = signed'(EW'(qy));
    return (sbx - sax) * (sqy - say) - (sby - say) * (sqx - sax);
  endfunction

  function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a, b, c);
    logic [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a, b, c);
    logic [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  logic signed [EW-1:0] area, e01, e12, e20;
  logic [COORD_W-1:0]   bx_min, bx_max, by_min, by_max, bx_raw, by_raw;
  logic                 covered, degenerate, advance;

  always_comb begin
    area   = edge_fn(vx0, vy0, vx1, vy1, vx2, vy2);
    e01    = edge_fn(vx0, vy0, vx1, vy1, cx, cy);
    e12    = edge_fn(vx1, vy1, vx2, vy2, cx, cy);
    e20    = edge_fn(vx2, vy2, vx0, vy0, cx, cy);
    bx_min = min3(vx0, vx1, vx2);
    by_min = min3(vy0, vy1, vy2);
    bx_raw = max3(vx0, vx1, vx2);
    by_raw = max3(vy0, vy1, vy2);
    bx_max = (bx_raw > COORD_W'(X_MAX)) ? COORD_W'(X_MAX) : bx_raw;
    by_max = (by_raw > COORD_W'(Y_MAX)) ? COORD_W'(Y_MAX) : by_raw;
    degenerate = (area == '0) || (bx_min > bx_max) || (by_min > by_max);
    // Edge samples count as inside, so both windings use a non-strict test.
    if (area_neg)
      covered = (e01[EW-1] || e01 == '0) && (e12[EW-1] || e12 == '0) &&
                (e20[EW-1] || e20 == '0);
    else
      covered = !e01[EW-1] && !e12[EW-1] && !e20[EW-1];
    advance = !px_valid || px_ready;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      px_valid <= 1'b0;
      px_x     <= '0;
      px_y     <= '0;
      done     <= 1'b0;
      vx0 <= '0; vy0 <= '0; vx1 <= '0; vy1 <= '0; vx2 <= '0; vy2 <= '0;
      xmin <= '0; xmax <= '0; ymin <= '0; ymax <= '0;
      cx <= '0; cy <= '0;
      area_neg <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            vx0 <= x0; vy0 <= y0; vx1 <= x1; vy1 <= y1; vx2 <= x2; vy2 <= y2;
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          xmin     <= bx_min;
          xmax     <= bx_max;
          ymin     <= by_min;
          ymax     <= by_max;
          cx       <= bx_min;
          cy       <= by_min;
          area_neg <= area[EW-1];
          if (degenerate) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (advance) begin
            px_valid <= covered;
            if (covered) begin
              px_x <= cx;
              px_y <= cy;
            end
            if (cx == xmax) begin
              cx <= xmin;
              if (cy == ymax) state <= S_DRAIN;
              else            cy <= cy + 1'b1;
            end else begin
              cx <= cx + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (advance) begin
            px_valid <= 1'b0;
            state    <= S_DONE;
            done     <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;
endmodule

// File: tb/tb_tri_raster_walker.sv
// Bench for tri_raster_walker: directed and random triangles scored against a
// full-screen coverage model, with backpressure, reset and input-hold scenarios.
module tb_tri_raster_walker;
  localparam int X_MAX = 159;
  localparam int Y_MAX = 119;

  logic       clk = 1'b0;
  logic       resetn;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] x0, y0, x1, y1, x2, y2;
  logic       px_valid;
  logic       px_ready;
  logic [7:0] px_x, px_y;
  logic       busy, done;
  logic [2:0] dbg_state;

  tri_raster_walker #(.COORD_W(8), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x), .px_y(px_y),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int bp_mode = 0;
  int hs_cnt = 0;
  int stall_left = 0;
  int first_px_cyc = -1;
  int done_cnt = 0;
  int done_cyc = 0;
  int acc_cyc = 0;
  logic        prev_stall = 1'b0;
  logic        prev_done = 1'b0;
  logic [15:0] prev_pix = '0;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: every screen pixel whose three edge values share the winding sign.
  task automatic build_model(input int ax, ay, bx, by, cx, cy);
    int area, e0, e1, e2;
    logic [7:0] xs, ys;
    exp_q.delete();
    area = (bx - ax) * (cy - ay) - (cx - ax) * (by - ay);
    if (area == 0) return;
    for (int y = 0; y <= Y_MAX; y++)
      for (int x = 0; x <= X_MAX; x++) begin
        e0 = (bx - ax) * (y - ay) - (by - ay) * (x - ax);
        e1 = (cx - bx) * (y - by) - (cy - by) * (x - bx);
        e2 = (ax - cx) * (y - cy) - (ay - cy) * (x - cx);
        if ((area > 0 && e0 >= 0 && e1 >= 0 && e2 >= 0) ||
            (area < 0 && e0 <= 0 && e1 <= 0 && e2 <= 0)) begin
          xs = 8'(x);
          ys = 8'(y);
          exp_q.push_back({xs, ys});
        end
      end
  endtask

  // ---------------- monitor / px_ready driver ----------------
  always @(negedge clk) begin
    logic [15:0] e;
    if (!resetn) begin
      px_ready   = 1'b1;
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      case (bp_mode)
        1: px_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (px_valid && hs_cnt == 1 && stall_left > 0) begin
            px_ready = 1'b0;
            stall_left--;
            chk("stall_px_x", int'(px_x), 1);
            chk("stall_px_y", int'(px_y), 0);
          end else px_ready = 1'b1;
        end
        default: px_ready = 1'b1;
      endcase
      if (prev_stall) begin
        chk("hold_valid", int'(px_valid), 1);
        chk("hold_pix", int'({px_x, px_y}), int'(prev_pix));
      end
      if (px_valid && first_px_cyc < 0) first_px_cyc = cyc;
      if (px_valid && px_ready) begin
        if (exp_q.size() == 0) chk("unexpected_px", int'({px_x, px_y}), -1);
        else begin
          e = exp_q.pop_front();
          chk("px", int'({px_x, px_y}), int'(e));
        end
        hs_cnt++;
      end
      prev_stall = px_valid && !px_ready;
      prev_pix   = {px_x, px_y};
      if (done) begin
        chk("missing_px", exp_q.size(), 0);
        chk("done_single", int'(prev_done), 0);
        done_cnt++;
        done_cyc = cyc;
      end
      prev_done = done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_tri(input int ax, ay, bx, by, cx, cy, input int mode, input bit junk);
    int n;
    build_model(ax, ay, bx, by, cx, cy);
    bp_mode = mode;
    stall_left = 3;
    hs_cnt = 0;
    first_px_cyc = -1;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk("idle_before_start", int'(in_ready), 1);
    x0 = 8'(ax); y0 = 8'(ay); x1 = 8'(bx); y1 = 8'(by); x2 = 8'(cx); y2 = 8'(cy);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (junk) begin
      // A second triangle held on the inputs while busy must not disturb this one.
      for (int k = 0; k < 4; k++) begin
        x0 = 8'($urandom_range(0, 255)); y0 = 8'($urandom_range(0, 255));
        x1 = 8'($urandom_range(0, 255)); y1 = 8'($urandom_range(0, 255));
        x2 = 8'($urandom_range(0, 255)); y2 = 8'($urandom_range(0, 255));
        @(negedge clk);
        chk("in_ready_busy", int'(in_ready), 0);
        chk("busy_flag", int'(busy), 1);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_tri(input int start_done);
    int n;
    n = 0;
    while (done_cnt == start_done && n < 30000) begin @(negedge clk); n++; end
    chk("done_seen", done_cnt - start_done, 1);
    @(negedge clk);
    chk("done_dropped", int'(done), 0);
    chk("ready_after_done", int'(in_ready), 1);
    chk("busy_after_done", int'(busy), 0);
  endtask

  task automatic run_tri(input int ax, ay, bx, by, cx, cy, input int mode, input bit junk);
    int sd;
    sd = done_cnt;
    start_tri(ax, ay, bx, by, cx, cy, mode, junk);
    finish_tri(sd);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, sd;
    resetn = 1'b0; in_valid = 1'b0; px_ready = 1'b1;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; x2 = '0; y2 = '0;
    #1;
    chk("rst_px_valid", int'(px_valid), 0);
    chk("rst_px_x", int'(px_x), 0);
    chk("rst_px_y", int'(px_y), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);

    // Right triangle, counter-clockwise: 15 pixels with x+y<=4.
    run_tri(0, 0, 4, 0, 0, 4, 0, 1'b0);
    chk("t1_count", hs_cnt, 15);
    chk("t1_first_latency", first_px_cyc - acc_cyc, 2);

    // Same triangle clockwise.
    run_tri(0, 0, 0, 4, 4, 0, 0, 1'b0);
    chk("t2_count", hs_cnt, 15);

    // Collinear: done visible in the cycle ending two edges after accept.
    run_tri(0, 0, 2, 2, 4, 4, 0, 1'b0);
    chk("t3_no_px", first_px_cyc, -1);
    chk("t3_done_latency", done_cyc - acc_cyc, 1);

    // Three-cycle stall on the second pixel.
    run_tri(0, 0, 4, 0, 0, 4, 2, 1'b0);
    chk("t4_count", hs_cnt, 15);
    chk("t4_stalled", stall_left, 0);

    // Partly off-screen triangle gets clipped to the visible area.
    run_tri(150, 110, 200, 110, 150, 200, 1, 1'b0);
    chk("t5_count", hs_cnt, 100);

    // Reset in the middle of a scan.
    sd = done_cnt;
    start_tri(0, 0, 4, 0, 0, 4, 0, 1'b0);
    n = 0;
    while (hs_cnt < 5 && n < 200) begin @(negedge clk); n++; end
    chk("t6_reached_scan", int'(hs_cnt >= 5), 1);
    @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("t6_px_valid", int'(px_valid), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_done", int'(done), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_in_ready", int'(in_ready), 1);
    chk("t6_no_done", done_cnt - sd, 0);
    run_tri(0, 0, 4, 0, 0, 4, 0, 1'b0);
    chk("t6_rerun_count", hs_cnt, 15);

    // New vertices presented while busy are ignored.
    run_tri(0, 0, 4, 0, 0, 4, 0, 1'b1);
    chk("t7_count", hs_cnt, 15);

    // Random small triangles, some crossing the screen edge, random backpressure.
    for (int t = 0; t < 8; t++) begin
      int bxo, byo;
      bxo = $urandom_range(0, 170);
      byo = $urandom_range(0, 130);
      run_tri(bxo + $urandom_range(0, 14), byo + $urandom_range(0, 14),
              bxo + $urandom_range(0, 14), byo + $urandom_range(0, 14),
              bxo + $urandom_range(0, 14), byo + $urandom_range(0, 14), 1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
